// File: rtl/hd_timing_pkg.sv
// Shared types, beat encodings and helpers for the HD-CPU beat/phase timing generator.
package hd_timing_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } state_e;

    localparam logic [2:0] W_1 = 3'b001;
    localparam logic [2:0] W_2 = 3'b010;
    localparam logic [2:0] W_3 = 3'b100;

    // Width of the within-phase clock counter; never narrower than one bit
    // so that PHASE_LEN=1 still yields a legal vector.
    function automatic int phase_cnt_w(input int phaseLen);
        int w;
        w = $clog2(phaseLen);
        return (w < 1) ? 1 : w;
    endfunction

    // Beat that follows the current one, given the controller requests seen
    // at the beat boundary. Anything that is not W2 or W1 (W3 or an illegal
    // pattern) falls back to W1.
    function automatic logic [2:0] next_beat(input logic [2:0] w,
                                             input logic       shortReq,
                                             input logic       longReq);
        case (w)
            W_1:     return shortReq ? W_1 : W_2;
            W_2:     return longReq  ? W_3 : W_1;
            default: return W_1;
        endcase
    endfunction

endpackage

// File: rtl/hd_edge_det.sv
// Two-flop synchronizer plus rising-edge detector for the console start button.
module hd_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // All stages come out of reset high, so a button already held down
    // through reset is not mistaken for a fresh press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/hd_timing_gen.sv
// Beat (W1-W3) and phase (T1-T3) generator for the HD-CPU hardwired controller.
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int PHASE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             QD,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    output logic [3:1]       W,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             RUN,
    output logic [CNT_W-1:0] MCYC
);

    localparam int PCW = phase_cnt_w(PHASE_LEN);
    localparam logic [PCW-1:0] PH_LAST = PCW'(PHASE_LEN - 1);

    state_e           state_q, state_d;
    logic [PCW-1:0]   phase_q, phase_d;
    logic [2:0]       w_q, w_d;
    logic [CNT_W-1:0] mcyc_q, mcyc_d;

    logic qdRise;
    logic phaseLast;

    hd_edge_det u_edge_det (
        .clk_i  (CLK),
        .rst_ni (CLR),
        .d_i    (QD),
        .rise_o (qdRise)
    );

    assign phaseLast = (phase_q == PH_LAST);

    // Registers for the sequencer; reset is immediate, even in the middle of a beat.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= HALT;
            phase_q <= '0;
            w_q     <= W_1;
            mcyc_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            w_q     <= w_d;
            mcyc_q  <= mcyc_d;
        end
    end

    // Phase sequencing; controller requests are only looked at on the last clock of PH3.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        w_d     = w_q;
        mcyc_d  = mcyc_q;
        unique case (state_q)
            HALT: begin
                if (qdRise) begin
                    state_d = PH1;
                    phase_d = '0;
                end
            end
            PH1: begin
                if (phaseLast) begin
                    state_d = PH2;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PCW'(1);
                end
            end
            PH2: begin
                if (phaseLast) begin
                    state_d = PH3;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PCW'(1);
                end
            end
            PH3: begin
                if (phaseLast) begin
                    phase_d = '0;
                    w_d     = next_beat(w_q, SHORT, LONG);
                    if (w_d == W_1) begin
                        mcyc_d = mcyc_q + CNT_W'(1);
                    end
                    state_d = STOP ? HALT : PH1;
                end else begin
                    phase_d = phase_q + PCW'(1);
                end
            end
            default: begin
                state_d = HALT;
                phase_d = '0;
            end
        endcase
    end

    assign W    = w_q;
    assign T1   = (state_q == PH1);
    assign T2   = (state_q == PH2);
    assign T3   = (state_q == PH3);
    assign RUN  = (state_q != HALT);
    assign MCYC = mcyc_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Self-checking bench for hd_timing_gen: a directed vector table plus random
// traffic, both compared against a beat-position reference model.
module tb_hd_timing_gen;

    logic CLK = 1'b0;
    logic CLR;
    logic QD;
    logic SHORT;
    logic LONG;
    logic STOP;

    logic [3:1] wA;
    logic       t1A, t2A, t3A, runA;
    logic [7:0] mcycA;

    logic [3:1] wB;
    logic       t1B, t2B, t3B, runB;
    logic [1:0] mcycB;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: single-clock phases, 8-bit cycle counter.
    hd_timing_gen #(.PHASE_LEN(1), .CNT_W(8)) dutA (
        .CLK(CLK), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
        .W(wA), .T1(t1A), .T2(t2A), .T3(t3A), .RUN(runA), .MCYC(mcycA)
    );

    // Instance B: three-clock phases, 2-bit counter to exercise the wrap.
    hd_timing_gen #(.PHASE_LEN(3), .CNT_W(2)) dutB (
        .CLK(CLK), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
        .W(wB), .T1(t1B), .T2(t2B), .T3(t3B), .RUN(runB), .MCYC(mcycB)
    );

    always #5 CLK = ~CLK;

    // Reference model: each instance is described by whether it is running,
    // the clock position inside the current beat (0 .. 3*L-1), the beat number
    // 1..3 and a machine-cycle count. QD is seen through a press history.
    int mL[2]    = '{1, 3};
    int mMod[2]  = '{256, 4};
    bit mRun[2]  = '{0, 0};
    int mTick[2] = '{0, 0};
    int mBeat[2] = '{1, 1};
    int mCyc[2]  = '{0, 0};
    bit qdHist[3] = '{1, 1, 1};

    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < 2; i++) begin
                mRun[i]  = 0;
                mTick[i] = 0;
                mBeat[i] = 1;
                mCyc[i]  = 0;
            end
            qdHist = '{1, 1, 1};
        end else begin
            bit pressed;
            pressed = qdHist[1] && !qdHist[2];
            for (int i = 0; i < 2; i++) begin
                if (!mRun[i]) begin
                    if (pressed) begin
                        mRun[i]  = 1;
                        mTick[i] = 0;
                    end
                end else if (mTick[i] == 3 * mL[i] - 1) begin
                    if (mBeat[i] == 1)      mBeat[i] = SHORT ? 1 : 2;
                    else if (mBeat[i] == 2) mBeat[i] = LONG ? 3 : 1;
                    else                    mBeat[i] = 1;
                    if (mBeat[i] == 1) mCyc[i] = (mCyc[i] + 1) % mMod[i];
                    mTick[i] = 0;
                    if (STOP) mRun[i] = 0;
                end else begin
                    mTick[i] = mTick[i] + 1;
                end
            end
            qdHist[2] = qdHist[1];
            qdHist[1] = qdHist[0];
            qdHist[0] = QD;
        end
    end

    function automatic logic [2:0] modelW(input int i);
        return 3'(1 << (mBeat[i] - 1));
    endfunction

    function automatic logic [2:0] modelT(input int i);
        if (!mRun[i]) return 3'b000;
        return 3'(1 << (mTick[i] / mL[i]));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " A.W"},    32'(wA),                32'(modelW(0)));
        checkOutput({tag, " A.T"},    32'({t3A, t2A, t1A}),   32'(modelT(0)));
        checkOutput({tag, " A.RUN"},  32'(runA),              32'(mRun[0]));
        checkOutput({tag, " A.MCYC"}, 32'(mcycA),             32'(mCyc[0]));
        checkOutput({tag, " B.W"},    32'(wB),                32'(modelW(1)));
        checkOutput({tag, " B.T"},    32'({t3B, t2B, t1B}),   32'(modelT(1)));
        checkOutput({tag, " B.RUN"},  32'(runB),              32'(mRun[1]));
        checkOutput({tag, " B.MCYC"}, 32'(mcycB),             32'(mCyc[1]));
    endtask

    task automatic applyStimulus(input logic clr, input logic qd, input logic sh,
                                 input logic lo, input logic st);
        CLR   = clr;
        QD    = qd;
        SHORT = sh;
        LONG  = lo;
        STOP  = st;
    endtask

    // One clock: outputs are sampled on the falling edge after the active edge.
    task automatic stepClk(input string tag);
        @(posedge CLK);
        @(negedge CLK);
        checkModel(tag);
    endtask

    typedef struct {
        logic       clr, qd, sh, lo, st;
        logic [2:0] w;
        logic [2:0] t;
        logic       run;
        int         mcyc;
    } vec_t;

    vec_t vecs[$];

    task automatic addRow(input int n, input logic clr, input logic qd, input logic sh,
                          input logic lo, input logic st, input logic [2:0] w,
                          input logic [2:0] t, input logic run, input int m);
        vec_t v;
        v.clr = clr; v.qd = qd; v.sh = sh; v.lo = lo; v.st = st;
        v.w = w; v.t = t; v.run = run; v.mcyc = m;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Hard stop if anything stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Expected values below are for instance A ({T3,T2,T1} in the t column).
        // Reset held with QD high, then released: no start.
        addRow(3, 0,1,0,0,0, 3'b001, 3'b000, 0, 0);
        addRow(4, 1,1,0,0,0, 3'b001, 3'b000, 0, 0);
        addRow(3, 1,0,0,0,0, 3'b001, 3'b000, 0, 0);
        // Press: edge reaches the sequencer two clocks later, T1 follows.
        addRow(2, 1,1,0,0,0, 3'b001, 3'b000, 0, 0);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b001, 1, 0);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b010, 1, 0);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b100, 1, 0);
        // Normal beats: W1, W2 alternate.
        addRow(1, 1,1,0,0,0, 3'b010, 3'b001, 1, 0);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b010, 1, 0);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b100, 1, 0);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b001, 1, 1);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b010, 1, 1);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b100, 1, 1);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b001, 1, 1);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b010, 1, 1);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b100, 1, 1);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b001, 1, 2);
        // LONG held: ignored in W1, inserts W3 after W2.
        addRow(1, 1,1,0,1,0, 3'b001, 3'b010, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b001, 3'b100, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b010, 3'b001, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b010, 3'b010, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b010, 3'b100, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b100, 3'b001, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b100, 3'b010, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b100, 3'b100, 1, 2);
        addRow(1, 1,1,0,1,0, 3'b001, 3'b001, 1, 3);
        // SHORT+STOP in W1: ignored mid-beat, acted on at the boundary.
        addRow(1, 1,1,1,0,1, 3'b001, 3'b010, 1, 3);
        addRow(1, 1,1,1,0,1, 3'b001, 3'b100, 1, 3);
        addRow(1, 1,1,1,0,1, 3'b001, 3'b000, 0, 4);
        // Resume with a new press.
        addRow(2, 1,0,0,0,0, 3'b001, 3'b000, 0, 4);
        addRow(2, 1,1,0,0,0, 3'b001, 3'b000, 0, 4);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b001, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b010, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b100, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b001, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b010, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b010, 3'b100, 1, 4);
        // LONG+STOP in W2: halts with W3 pending.
        addRow(1, 1,1,0,1,1, 3'b100, 3'b000, 0, 4);
        addRow(2, 1,0,0,0,0, 3'b100, 3'b000, 0, 4);
        addRow(2, 1,1,0,0,0, 3'b100, 3'b000, 0, 4);
        addRow(1, 1,1,0,0,0, 3'b100, 3'b001, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b100, 3'b010, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b100, 3'b100, 1, 4);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b001, 1, 5);
        addRow(1, 1,1,0,0,0, 3'b001, 3'b010, 1, 5);

        @(negedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].qd, vecs[i].sh, vecs[i].lo, vecs[i].st);
            stepClk($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d W", i),    32'(wA),              32'(vecs[i].w));
            checkOutput($sformatf("vec%0d T", i),    32'({t3A, t2A, t1A}), 32'(vecs[i].t));
            checkOutput($sformatf("vec%0d RUN", i),  32'(runA),            32'(vecs[i].run));
            checkOutput($sformatf("vec%0d MCYC", i), 32'(mcycA),           32'(vecs[i].mcyc));
        end

        // Reset dropped while A is in T2: outputs clear before the next clock.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("midrst A.W",    32'(wA),              32'h1);
        checkOutput("midrst A.T",    32'({t3A, t2A, t1A}), 32'h0);
        checkOutput("midrst A.RUN",  32'(runA),            32'h0);
        checkOutput("midrst A.MCYC", 32'(mcycA),           32'h0);
        checkOutput("midrst B.RUN",  32'(runB),            32'h0);
        checkOutput("midrst B.MCYC", 32'(mcycB),           32'h0);
        checkModel("midrst");
        stepClk("rsthold");
        stepClk("rsthold");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) stepClk("rstrel");
        checkOutput("held QD no start", 32'(runA), 32'h0);

        // SHORT beats on B: each phase three clocks, counter wraps 1,2,3,0.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) stepClk("bprep");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            stepClk("bstart");
            seen = t1B;
        end
        checkOutput("B start within bound", 32'(seen), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            repeat (9) stepClk("bbeat");
            checkOutput($sformatf("B MCYC beat%0d", k), 32'(mcycB), 32'(k % 4));
            checkOutput($sformatf("B T1 beat%0d", k),   32'(t1B),   32'h1);
        end

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            logic clr, qd;
            clr = ($urandom_range(0, 63) != 0);
            qd  = ($urandom_range(0, 3) == 0) ? ~QD : QD;
            applyStimulus(clr, qd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0));
            stepClk("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
